procyon_ram_mp: RTL and testbench

PROCYON_RAM_MP -- requirements
Module: procyon_ram_mp

---
 rtl/procyon_lib_pkg.sv | 12 +
 rtl/procyon_ram_rd_port.sv | 60 ++++++
 rtl/procyon_ram_mp.sv | 107 ++++++++++
 tb/tb_procyon_ram_mp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/procyon_lib_pkg.sv
// Shared types and constants for the procyon RAM blocks.
package procyon_lib_pkg;

    typedef enum logic {
        PROCYON_RAM_MP_INIT  = 1'b0,
        PROCYON_RAM_MP_READY = 1'b1
    } procyon_ram_mp_state_t;

    localparam int PROCYON_RAM_LATENCY_COMB = 0;
    localparam int PROCYON_RAM_LATENCY_REG  = 1;

endpackage

// File: rtl/procyon_ram_rd_port.sv
// One read port: accept gating, lane-wise write-first forwarding and the
// combinational or registered output stage.
module procyon_ram_rd_port #(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_RD_LATENCY    = 1,
    parameter int OPTN_WR_MASK_WIDTH = 4,
    parameter int RAM_IDX_WIDTH      = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_ram_ready,
    input  logic                          i_rd_en,
    input  logic [RAM_IDX_WIDTH-1:0]      i_rd_addr,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_rd_word,
    input  logic                          i_wr_en,
    input  logic [RAM_IDX_WIDTH-1:0]      i_wr_addr,
    input  logic [OPTN_WR_MASK_WIDTH-1:0] i_wr_mask,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_wr_data,
    output logic [OPTN_DATA_WIDTH-1:0]    o_rd_data,
    output logic                          o_rd_valid
);
    import procyon_lib_pkg::*;

    localparam int LANE_W    = OPTN_DATA_WIDTH / OPTN_WR_MASK_WIDTH;
    localparam bit COMB_READ = (OPTN_RD_LATENCY == PROCYON_RAM_LATENCY_COMB);

    logic                       rd_accept;
    logic [OPTN_DATA_WIDTH-1:0] fwd_word;
    logic [OPTN_DATA_WIDTH-1:0] rd_data_q;
    logic                       rd_valid_q;

    assign rd_accept = i_ram_ready & i_rd_en;

    // i_wr_en is the already-qualified write, so an out-of-range address never forwards.
    always_comb begin
        fwd_word = i_rd_word;
        if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            for (int l = 0; l < OPTN_WR_MASK_WIDTH; l++) begin
                if (i_wr_mask[l]) begin
                    fwd_word[l*LANE_W +: LANE_W] = i_wr_data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            rd_data_q  <= rd_accept ? fwd_word : '0;
        end
    end

    // The combinational path deliberately sees the pre-write word.
    assign o_rd_data  = COMB_READ ? (rd_accept ? i_rd_word : '0) : rd_data_q;
    assign o_rd_valid = COMB_READ ? rd_accept : rd_valid_q;

endmodule

// File: rtl/procyon_ram_mp.sv
// Multi-read-port RAM with lane write mask; clears itself after reset before
// accepting any access.
module procyon_ram_mp #(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_RAM_DEPTH     = 16,
    parameter int OPTN_RD_PORTS      = 2,
    parameter int OPTN_RD_LATENCY    = 1,
    parameter int OPTN_WR_MASK_WIDTH = 4,
    parameter int RAM_IDX_WIDTH      = $clog2(OPTN_RAM_DEPTH)
) (
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic [OPTN_RD_PORTS-1:0]                 i_ram_rd_en,
    input  logic [OPTN_RD_PORTS*RAM_IDX_WIDTH-1:0]   i_ram_rd_addr,
    output logic [OPTN_RD_PORTS*OPTN_DATA_WIDTH-1:0] o_ram_rd_data,
    output logic [OPTN_RD_PORTS-1:0]                 o_ram_rd_valid,
    input  logic                                     i_ram_wr_en,
    input  logic [RAM_IDX_WIDTH-1:0]                 i_ram_wr_addr,
    input  logic [OPTN_WR_MASK_WIDTH-1:0]            i_ram_wr_mask,
    input  logic [OPTN_DATA_WIDTH-1:0]               i_ram_wr_data,
    output logic                                     o_ram_ready
);
    import procyon_lib_pkg::*;

    localparam int                     LANE_W    = OPTN_DATA_WIDTH / OPTN_WR_MASK_WIDTH;
    localparam logic [RAM_IDX_WIDTH:0] DEPTH_EXT = (RAM_IDX_WIDTH+1)'(OPTN_RAM_DEPTH);
    localparam logic [RAM_IDX_WIDTH-1:0] LAST_IDX = RAM_IDX_WIDTH'(OPTN_RAM_DEPTH - 1);

    procyon_ram_mp_state_t      state;
    logic [RAM_IDX_WIDTH-1:0]   init_cnt;
    logic                       ready_q;
    logic                       wr_accept;
    logic [OPTN_DATA_WIDTH-1:0] ram [OPTN_RAM_DEPTH];
    logic [OPTN_DATA_WIDTH-1:0] rd_word [OPTN_RD_PORTS];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= PROCYON_RAM_MP_INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                PROCYON_RAM_MP_INIT: begin
                    if (init_cnt == LAST_IDX) begin
                        state   <= PROCYON_RAM_MP_READY;
                        ready_q <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= PROCYON_RAM_MP_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign wr_accept = ready_q & i_ram_wr_en & ({1'b0, i_ram_wr_addr} < DEPTH_EXT);

    // The array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state == PROCYON_RAM_MP_INIT) begin
            ram[init_cnt] <= '0;
        end else if (wr_accept) begin
            for (int l = 0; l < OPTN_WR_MASK_WIDTH; l++) begin
                if (i_ram_wr_mask[l]) begin
                    ram[i_ram_wr_addr][l*LANE_W +: LANE_W] <= i_ram_wr_data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < OPTN_RD_PORTS; p++) begin
            rd_word[p] = '0;
            if ({1'b0, i_ram_rd_addr[p*RAM_IDX_WIDTH +: RAM_IDX_WIDTH]} < DEPTH_EXT) begin
                rd_word[p] = ram[i_ram_rd_addr[p*RAM_IDX_WIDTH +: RAM_IDX_WIDTH]];
            end
        end
    end

    for (genvar g = 0; g < OPTN_RD_PORTS; g++) begin : g_rd_port
        procyon_ram_rd_port #(
            .OPTN_DATA_WIDTH    (OPTN_DATA_WIDTH),
            .OPTN_RD_LATENCY    (OPTN_RD_LATENCY),
            .OPTN_WR_MASK_WIDTH (OPTN_WR_MASK_WIDTH),
            .RAM_IDX_WIDTH      (RAM_IDX_WIDTH)
        ) u_rd_port (
            .clk         (clk),
            .n_rst       (n_rst),
            .i_ram_ready (ready_q),
            .i_rd_en     (i_ram_rd_en[g]),
            .i_rd_addr   (i_ram_rd_addr[g*RAM_IDX_WIDTH +: RAM_IDX_WIDTH]),
            .i_rd_word   (rd_word[g]),
            .i_wr_en     (wr_accept),
            .i_wr_addr   (i_ram_wr_addr),
            .i_wr_mask   (i_ram_wr_mask),
            .i_wr_data   (i_ram_wr_data),
            .o_rd_data   (o_ram_rd_data[g*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH]),
            .o_rd_valid  (o_ram_rd_valid[g])
        );
    end

    assign o_ram_ready = ready_q;

endmodule

// File: tb/tb_procyon_ram_mp.sv
// Directed bench: a default RAM (depth 16, latency 1), a depth-12 RAM and a
// latency-0 single-port RAM share one stimulus stream.
module tb_procyon_ram_mp;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;

    logic [63:0] d0_data;
    logic [1:0]  d0_valid;
    logic        d0_ready;
    logic [63:0] d1_data;
    logic [1:0]  d1_valid;
    logic        d1_ready;
    logic [31:0] d2_data;
    logic [0:0]  d2_valid;
    logic        d2_ready;

    int tests    = 0;
    int failures = 0;
    int cnt;
    int d1_cycle;
    int d2_cycle;

    always #5 clk = ~clk;

    procyon_ram_mp u_dut0 (
        .clk(clk), .n_rst(n_rst),
        .i_ram_rd_en(rd_en), .i_ram_rd_addr(rd_addr),
        .o_ram_rd_data(d0_data), .o_ram_rd_valid(d0_valid),
        .i_ram_wr_en(wr_en), .i_ram_wr_addr(wr_addr),
        .i_ram_wr_mask(wr_mask), .i_ram_wr_data(wr_data),
        .o_ram_ready(d0_ready)
    );

    procyon_ram_mp #(.OPTN_RAM_DEPTH(12)) u_dut1 (
        .clk(clk), .n_rst(n_rst),
        .i_ram_rd_en(rd_en), .i_ram_rd_addr(rd_addr),
        .o_ram_rd_data(d1_data), .o_ram_rd_valid(d1_valid),
        .i_ram_wr_en(wr_en), .i_ram_wr_addr(wr_addr),
        .i_ram_wr_mask(wr_mask), .i_ram_wr_data(wr_data),
        .o_ram_ready(d1_ready)
    );

    procyon_ram_mp #(.OPTN_RD_PORTS(1), .OPTN_RD_LATENCY(0)) u_dut2 (
        .clk(clk), .n_rst(n_rst),
        .i_ram_rd_en(rd_en[0:0]), .i_ram_rd_addr(rd_addr[3:0]),
        .o_ram_rd_data(d2_data), .o_ram_rd_valid(d2_valid),
        .i_ram_wr_en(wr_en), .i_ram_wr_addr(wr_addr),
        .i_ram_wr_mask(wr_mask), .i_ram_wr_data(wr_data),
        .o_ram_ready(d2_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ren, input logic [3:0] ra0, input logic [3:0] ra1,
                                 input logic wen, input logic [3:0] wa, input logic [3:0] wm,
                                 input logic [31:0] wd);
        rd_en   = ren;
        rd_addr = {ra1, ra0};
        wr_en   = wen;
        wr_addr = wa;
        wr_mask = wm;
        wr_data = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady(input string tag);
        cnt      = 0;
        d1_cycle = 0;
        d2_cycle = 0;
        while (!d0_ready && cnt < 40) begin
            tick();
            cnt++;
            if (d1_ready && d1_cycle == 0) d1_cycle = cnt;
            if (d2_ready && d2_cycle == 0) d2_cycle = cnt;
        end
        checkOutput({tag, "_ready_cycles"}, 64'(cnt), 64'd16);
        checkOutput({tag, "_d12_ready_cycles"}, 64'(d1_cycle), 64'd12);
        checkOutput({tag, "_lat0_ready_cycles"}, 64'(d2_cycle), 64'd16);
    endtask

    initial begin
        n_rst = 1'b0;
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        tick();
        tick();
        checkOutput("rst_ready", 64'(d0_ready), 64'd0);
        checkOutput("rst_valid", 64'(d0_valid), 64'd0);
        checkOutput("rst_data", d0_data, 64'd0);

        // Release reset with a write and reads pending during INIT.
        applyStimulus(2'b11, 4'd5, 4'd5, 1'b1, 4'd5, 4'hF, 32'hAAAAAAAA);
        n_rst = 1'b1;
        cnt = 0;
        d1_cycle = 0;
        d2_cycle = 0;
        while (!d0_ready && cnt < 40) begin
            tick();
            cnt++;
            if (d1_ready && d1_cycle == 0) d1_cycle = cnt;
            if (d2_ready && d2_cycle == 0) d2_cycle = cnt;
            if (cnt == 3) begin
                checkOutput("init_valid", 64'(d0_valid), 64'd0);
                checkOutput("init_data", d0_data, 64'd0);
            end
        end
        checkOutput("init_ready_cycles", 64'(cnt), 64'd16);
        checkOutput("init_d12_ready_cycles", 64'(d1_cycle), 64'd12);
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);

        // Address 5 is zero; the INIT-time write was dropped.
        applyStimulus(2'b11, 4'd5, 4'd5, 1'b0, 4'd0, 4'h0, 32'h0);
        checkOutput("lat0_rd5_data", 64'(d2_data), 64'd0);
        checkOutput("lat0_rd5_valid", 64'(d2_valid), 64'd1);
        tick();
        checkOutput("rd5_data", d0_data, 64'd0);
        checkOutput("rd5_valid", 64'(d0_valid), 64'd3);

        // Masked write merge.
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b1, 4'd3, 4'b1111, 32'hDEADBEEF);
        tick();
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b1, 4'd3, 4'b0101, 32'h11223344);
        tick();
        applyStimulus(2'b01, 4'd3, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        checkOutput("lat0_mask_merge", 64'(d2_data), 64'hDE22BE44);
        tick();
        checkOutput("mask_merge_p0", d0_data[31:0], 64'hDE22BE44);
        checkOutput("rd_en_low_p1", d0_data[63:32], 64'd0);
        checkOutput("mask_merge_valid", 64'(d0_valid), 64'b01);
        checkOutput("d12_mask_merge", d1_data[31:0], 64'hDE22BE44);

        // Write-first forwarding per lane on a same-cycle collision.
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b1, 4'd7, 4'hF, 32'h12345678);
        tick();
        applyStimulus(2'b01, 4'd7, 4'd0, 1'b1, 4'd7, 4'b1100, 32'hCAFEF00D);
        checkOutput("lat0_collide_old", 64'(d2_data), 64'h12345678);
        tick();
        checkOutput("fwd_data", d0_data[31:0], 64'hCAFE5678);
        checkOutput("fwd_valid", 64'(d0_valid), 64'b01);
        applyStimulus(2'b01, 4'd7, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        tick();
        checkOutput("fwd_stored", d0_data[31:0], 64'hCAFE5678);

        // Independent ports in the same cycle.
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b1, 4'd2, 4'hF, 32'h02020202);
        tick();
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b1, 4'd9, 4'hF, 32'h09090909);
        tick();
        applyStimulus(2'b11, 4'd2, 4'd9, 1'b0, 4'd0, 4'h0, 32'h0);
        tick();
        checkOutput("dual_data", d0_data, 64'h09090909_02020202);
        checkOutput("dual_valid", 64'(d0_valid), 64'b11);
        checkOutput("d12_dual_data", d1_data, 64'h09090909_02020202);

        // Out-of-range on the depth-12 instance.
        applyStimulus(2'b01, 4'd14, 4'd0, 1'b1, 4'd14, 4'hF, 32'hFFFFFFFF);
        tick();
        checkOutput("d12_oor_data", d1_data[31:0], 64'd0);
        checkOutput("d12_oor_valid", 64'(d1_valid), 64'b01);
        checkOutput("d16_addr14_fwd", d0_data[31:0], 64'hFFFFFFFF);
        applyStimulus(2'b01, 4'd14, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        tick();
        checkOutput("d12_oor_reread", d1_data[31:0], 64'd0);
        checkOutput("d16_addr14_stored", d0_data[31:0], 64'hFFFFFFFF);

        applyStimulus(2'b11, 4'd3, 4'd3, 1'b0, 4'd0, 4'h0, 32'h0);
        tick();
        checkOutput("same_addr_both", d0_data, 64'hDE22BE44_DE22BE44);

        // Reset mid-READY, then again mid-INIT.
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        n_rst = 1'b0;
        #1;
        checkOutput("midrst_ready", 64'(d0_ready), 64'd0);
        checkOutput("midrst_valid", 64'(d0_valid), 64'd0);
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("midinit_ready", 64'(d0_ready), 64'd0);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        waitReady("reinit");

        for (int a = 0; a < 16; a += 2) begin
            applyStimulus(2'b11, 4'(a), 4'(a + 1), 1'b0, 4'd0, 4'h0, 32'h0);
            tick();
            checkOutput($sformatf("clear_addr%0d", a), d0_data, 64'd0);
            checkOutput($sformatf("clear_valid%0d", a), 64'(d0_valid), 64'b11);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
